// File: rtl/ahbm_pkg.sv
// Shared AHB master definitions: FSM state encoding, AMBA field constants and
// a size-normalising helper reused by the PicoRV32 memory adapter.
package ahbm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
    ST_RESP2 = 3'd4,
    ST_DONE  = 3'd5
  } ahbm_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // Any size code wider than a half-word is issued as a word transfer.
  function automatic logic [2:0] ahbm_norm_size(input logic [2:0] size);
    logic [2:0] norm;
    case (size)
      HSIZE_BYTE: norm = HSIZE_BYTE;
      HSIZE_HALF: norm = HSIZE_HALF;
      default:    norm = HSIZE_WORD;
    endcase
    return norm;
  endfunction

endpackage

// File: rtl/ahbm_lane_rep.sv
// Write-data lane replication: the low-order byte or half-word is copied to
// every lane so the slave finds it regardless of which lane the address selects.
module ahbm_lane_rep
  import ahbm_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [31:0] wdata,
  output logic [31:0] wdata_rep
);

  // Replicate the active lanes according to the normalised transfer size.
  always_comb begin
    wdata_rep = wdata;
    case (size)
      HSIZE_BYTE: wdata_rep = {4{wdata[7:0]}};
      HSIZE_HALF: wdata_rep = {2{wdata[15:0]}};
      default:    wdata_rep = wdata;
    endcase
  end

endmodule

// File: rtl/picorv32_ahb_master.sv
// Single-transfer AHB 2.0 master behind the PicoRV32 memory adapter.
// Optional watchdog on bus waits is enabled by defining AHBM_TIMEOUT_EN.
module picorv32_ahb_master
  import ahbm_pkg::*;
#(
  parameter logic [3:0]  HMASTER_ID     = 4'd0,
  parameter int unsigned TIMEOUT_CYCLES = 32'd1023
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ui_valid,
  input  logic [31:0] ui_addr,
  input  logic [2:0]  ui_size,
  input  logic        ui_write,
  input  logic [31:0] ui_wdata,
  input  logic [3:0]  ui_prot,
  input  logic        ui_lock,
  output logic        ui_accept,
  output logic        ui_done,
  output logic        ui_error,
  output logic [31:0] ui_rdata,
  output logic        hbusreq,
  output logic        hlock,
  input  logic        hgrant,
  input  logic        hready,
  input  logic [1:0]  hresp,
  output logic [1:0]  htrans,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [3:0]  hprot,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  output logic [3:0]  hmaster_idx
);

  ahbm_state_e state_q, state_d;

  logic [31:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  prot_q, prot_d;
  logic        lock_q, lock_d;
  logic        err_s;

  logic        ui_accept_q, ui_accept_d;
  logic        ui_done_q, ui_done_d;
  logic        ui_error_q, ui_error_d;
  logic [31:0] ui_rdata_q, ui_rdata_d;
  logic        hbusreq_q, hbusreq_d;
  logic        hlock_q, hlock_d;
  logic [1:0]  htrans_q, htrans_d;
  logic [31:0] haddr_q, haddr_d;
  logic        hwrite_q, hwrite_d;
  logic [2:0]  hsize_q, hsize_d;
  logic [3:0]  hprot_q, hprot_d;
  logic [31:0] hwdata_q, hwdata_d;

  logic [2:0]  size_norm_s;
  logic [31:0] wdata_rep_s;

`ifdef AHBM_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic [15:0] tmo_next_s;
  logic        tmo_hit_s;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^TIMEOUT_CYCLES;
`endif

  assign size_norm_s = ahbm_norm_size(ui_size);

  // Replication is applied at capture so the held data is already bus-ready.
  ahbm_lane_rep u_lane_rep (
    .size      (size_norm_s),
    .wdata     (ui_wdata),
    .wdata_rep (wdata_rep_s)
  );

  // Next state, request capture and completion data.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    prot_d     = prot_q;
    lock_d     = lock_q;
    ui_rdata_d = ui_rdata_q;
    err_s      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ui_valid) begin
          state_d = ST_REQ;
          addr_d  = ui_addr;
          size_d  = size_norm_s;
          write_d = ui_write;
          wdata_d = wdata_rep_s;
          prot_d  = ui_prot;
          lock_d  = ui_lock;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (hgrant && hready) begin
          state_d = ST_ADDR;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_ADDR: begin
        if (hready) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (!hready) begin
          if (hresp == HRESP_OKAY) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_RESP2;
          end
        end else if (hresp == HRESP_OKAY) begin
          state_d    = ST_DONE;
          ui_rdata_d = hrdata;
        end else if (hresp == HRESP_ERROR) begin
          state_d = ST_DONE;
          err_s   = 1'b1;
        end else begin
          // A one-cycle RETRY/SPLIT is out of protocol; re-issue anyway.
          state_d = ST_REQ;
        end
      end
      ST_RESP2: begin
        if (!hready) begin
          state_d = ST_RESP2;
        end else if ((hresp == HRESP_RETRY) || (hresp == HRESP_SPLIT)) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_DONE;
          err_s   = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef AHBM_TIMEOUT_EN
    // REQ counts every stalled cycle so a missing grant also expires.
    if (state_d != state_q) begin
      tmo_next_s = 16'd0;
    end else if ((state_q == ST_REQ) ||
                 (((state_q == ST_DATA) || (state_q == ST_RESP2)) && !hready)) begin
      tmo_next_s = tmo_cnt_q + 16'd1;
    end else begin
      tmo_next_s = tmo_cnt_q;
    end
    tmo_hit_s = (state_q inside {ST_REQ, ST_DATA, ST_RESP2}) && (tmo_next_s == TIMEOUT_LIM);
    if (tmo_hit_s) begin
      state_d   = ST_DONE;
      err_s     = 1'b1;
      tmo_cnt_d = 16'd0;
    end else begin
      tmo_cnt_d = tmo_next_s;
    end
`endif
  end

  // Output values for the cycle after this edge, decoded from the next state.
  always_comb begin
    ui_accept_d = 1'b0;
    ui_done_d   = 1'b0;
    ui_error_d  = 1'b0;
    hbusreq_d   = 1'b0;
    hlock_d     = 1'b0;
    htrans_d    = HTRANS_IDLE;
    haddr_d     = 32'h0000_0000;
    hwrite_d    = 1'b0;
    hsize_d     = 3'b000;
    hprot_d     = 4'h0;
    hwdata_d    = 32'h0000_0000;

    if ((state_q == ST_IDLE) && (state_d == ST_REQ)) begin
      ui_accept_d = 1'b1;
    end else begin
      ui_accept_d = 1'b0;
    end

    case (state_d)
      ST_REQ: begin
        hbusreq_d = 1'b1;
        hlock_d   = lock_d;
      end
      ST_ADDR: begin
        hbusreq_d = 1'b1;
        hlock_d   = lock_d;
        htrans_d  = HTRANS_NONSEQ;
        haddr_d   = addr_d;
        hwrite_d  = write_d;
        hsize_d   = size_d;
        hprot_d   = prot_d;
      end
      ST_DATA: begin
        hlock_d  = lock_d;
        hwdata_d = wdata_d;
      end
      ST_RESP2: begin
        hlock_d = lock_d;
      end
      ST_DONE: begin
        hlock_d    = lock_d;
        ui_done_d  = 1'b1;
        ui_error_d = err_s;
      end
      default: begin
        hlock_d = 1'b0;
      end
    endcase
  end

  // State, captured request and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      addr_q      <= 32'h0000_0000;
      size_q      <= 3'b000;
      write_q     <= 1'b0;
      wdata_q     <= 32'h0000_0000;
      prot_q      <= 4'h0;
      lock_q      <= 1'b0;
      ui_accept_q <= 1'b0;
      ui_done_q   <= 1'b0;
      ui_error_q  <= 1'b0;
      ui_rdata_q  <= 32'h0000_0000;
      hbusreq_q   <= 1'b0;
      hlock_q     <= 1'b0;
      htrans_q    <= HTRANS_IDLE;
      haddr_q     <= 32'h0000_0000;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'b000;
      hprot_q     <= 4'h0;
      hwdata_q    <= 32'h0000_0000;
`ifdef AHBM_TIMEOUT_EN
      tmo_cnt_q   <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      prot_q      <= prot_d;
      lock_q      <= lock_d;
      ui_accept_q <= ui_accept_d;
      ui_done_q   <= ui_done_d;
      ui_error_q  <= ui_error_d;
      ui_rdata_q  <= ui_rdata_d;
      hbusreq_q   <= hbusreq_d;
      hlock_q     <= hlock_d;
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hprot_q     <= hprot_d;
      hwdata_q    <= hwdata_d;
`ifdef AHBM_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign ui_accept   = ui_accept_q;
  assign ui_done     = ui_done_q;
  assign ui_error    = ui_error_q;
  assign ui_rdata    = ui_rdata_q;
  assign hbusreq     = hbusreq_q;
  assign hlock       = hlock_q;
  assign htrans      = htrans_q;
  assign haddr       = haddr_q;
  assign hwrite      = hwrite_q;
  assign hsize       = hsize_q;
  assign hburst      = HBURST_SINGLE;
  assign hprot       = hprot_q;
  assign hwdata      = hwdata_q;
  assign hmaster_idx = HMASTER_ID;

endmodule

// File: tb/tb_picorv32_ahb_master.sv
// Directed bench for picorv32_ahb_master: cycle-exact steps, each output checked
// 1 ns after the rising edge against hand-computed values.
module tb_picorv32_ahb_master;

  logic        clk;
  logic        resetn;
  logic        ui_valid;
  logic [31:0] ui_addr;
  logic [2:0]  ui_size;
  logic        ui_write;
  logic [31:0] ui_wdata;
  logic [3:0]  ui_prot;
  logic        ui_lock;
  logic        ui_accept;
  logic        ui_done;
  logic        ui_error;
  logic [31:0] ui_rdata;
  logic        hbusreq;
  logic        hlock;
  logic        hgrant;
  logic        hready;
  logic [1:0]  hresp;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic [3:0]  hmaster_idx;

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef AHBM_TIMEOUT_EN
  localparam int GRANT_WAIT = 5;
`else
  localparam int GRANT_WAIT = 20;
`endif

  picorv32_ahb_master #(
    .HMASTER_ID     (4'd5),
    .TIMEOUT_CYCLES (32'd8)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .ui_valid    (ui_valid),
    .ui_addr     (ui_addr),
    .ui_size     (ui_size),
    .ui_write    (ui_write),
    .ui_wdata    (ui_wdata),
    .ui_prot     (ui_prot),
    .ui_lock     (ui_lock),
    .ui_accept   (ui_accept),
    .ui_done     (ui_done),
    .ui_error    (ui_error),
    .ui_rdata    (ui_rdata),
    .hbusreq     (hbusreq),
    .hlock       (hlock),
    .hgrant      (hgrant),
    .hready      (hready),
    .hresp       (hresp),
    .htrans      (htrans),
    .haddr       (haddr),
    .hwrite      (hwrite),
    .hsize       (hsize),
    .hburst      (hburst),
    .hprot       (hprot),
    .hwdata      (hwdata),
    .hrdata      (hrdata),
    .hmaster_idx (hmaster_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [31:0] addr, input logic [2:0] size, input logic wr,
                         input logic [31:0] wdata, input logic [3:0] prot, input logic lock);
    ui_valid = 1'b1;
    ui_addr  = addr;
    ui_size  = size;
    ui_write = wr;
    ui_wdata = wdata;
    ui_prot  = prot;
    ui_lock  = lock;
  endtask

  initial begin
    resetn   = 1'b0;
    ui_valid = 1'b0;
    ui_addr  = 32'h0;
    ui_size  = 3'b000;
    ui_write = 1'b0;
    ui_wdata = 32'h0;
    ui_prot  = 4'h0;
    ui_lock  = 1'b0;
    hgrant   = 1'b1;
    hready   = 1'b1;
    hresp    = 2'b00;
    hrdata   = 32'h0;

    // Reset state
    tick();
    tick();
    check("rst_htrans", {30'd0, htrans}, 32'd0);
    check("rst_hbusreq", {31'd0, hbusreq}, 32'd0);
    check("rst_ui_done", {31'd0, ui_done}, 32'd0);
    check("rst_haddr", haddr, 32'd0);
    check("rst_hwdata", hwdata, 32'd0);
    check("rst_hburst", {29'd0, hburst}, 32'd0);
    check("rst_hmaster_idx", {28'd0, hmaster_idx}, 32'd5);
    resetn = 1'b1;

    // Zero-wait word read
    request(32'h4000_0010, 3'b010, 1'b0, 32'h0, 4'h3, 1'b0);
    tick();
    check("rd_accept", {31'd0, ui_accept}, 32'd1);
    check("rd_req_busreq", {31'd0, hbusreq}, 32'd1);
    check("rd_req_htrans", {30'd0, htrans}, 32'd0);
    ui_valid = 1'b0;
    tick();
    check("rd_addr_htrans", {30'd0, htrans}, 32'd2);
    check("rd_addr_haddr", haddr, 32'h4000_0010);
    check("rd_addr_hsize", {29'd0, hsize}, 32'd2);
    check("rd_addr_hwrite", {31'd0, hwrite}, 32'd0);
    check("rd_addr_hprot", {28'd0, hprot}, 32'd3);
    check("rd_addr_accept", {31'd0, ui_accept}, 32'd0);
    hrdata = 32'hDEAD_BEEF;
    tick();
    check("rd_data_htrans", {30'd0, htrans}, 32'd0);
    check("rd_data_busreq", {31'd0, hbusreq}, 32'd0);
    check("rd_data_done", {31'd0, ui_done}, 32'd0);
    tick();
    check("rd_done", {31'd0, ui_done}, 32'd1);
    check("rd_rdata", ui_rdata, 32'hDEAD_BEEF);
    check("rd_error", {31'd0, ui_error}, 32'd0);

    // Byte write with two wait states, offered during the DONE cycle
    request(32'h4000_0003, 3'b000, 1'b1, 32'h0000_00A5, 4'hA, 1'b1);
    tick();
    check("b2b_no_accept_after_done", {31'd0, ui_accept}, 32'd0);
    check("b2b_done_cleared", {31'd0, ui_done}, 32'd0);
    tick();
    check("wr_accept", {31'd0, ui_accept}, 32'd1);
    check("wr_req_hlock", {31'd0, hlock}, 32'd1);
    ui_valid = 1'b0;
    tick();
    check("wr_addr_htrans", {30'd0, htrans}, 32'd2);
    check("wr_addr_hsize", {29'd0, hsize}, 32'd0);
    check("wr_addr_hwrite", {31'd0, hwrite}, 32'd1);
    check("wr_addr_haddr", haddr, 32'h4000_0003);
    check("wr_addr_hprot", {28'd0, hprot}, 32'hA);
    tick();
    check("wr_data1_hwdata", hwdata, 32'hA5A5_A5A5);
    check("wr_data1_htrans", {30'd0, htrans}, 32'd0);
    hready = 1'b0;
    tick();
    check("wr_wait1_done", {31'd0, ui_done}, 32'd0);
    check("wr_wait1_hwdata", hwdata, 32'hA5A5_A5A5);
    tick();
    check("wr_wait2_done", {31'd0, ui_done}, 32'd0);
    hready = 1'b1;
    tick();
    check("wr_done", {31'd0, ui_done}, 32'd1);
    check("wr_done_error", {31'd0, ui_error}, 32'd0);
    check("wr_done_hlock", {31'd0, hlock}, 32'd1);
    tick();
    check("wr_idle_hlock", {31'd0, hlock}, 32'd0);
    check("wr_idle_hwdata", hwdata, 32'd0);

    // Half-word write: RETRY on the first attempt, then OKAY
    request(32'h8000_0040, 3'b001, 1'b1, 32'h0000_1234, 4'h1, 1'b0);
    tick();
    check("rty_accept", {31'd0, ui_accept}, 32'd1);
    ui_valid = 1'b0;
    tick();
    check("rty_addr1_htrans", {30'd0, htrans}, 32'd2);
    check("rty_addr1_haddr", haddr, 32'h8000_0040);
    tick();
    check("rty_data1_hwdata", hwdata, 32'h1234_1234);
    hready = 1'b0;
    hresp  = 2'b10;
    tick();
    check("rty_resp2_done", {31'd0, ui_done}, 32'd0);
    check("rty_resp2_htrans", {30'd0, htrans}, 32'd0);
    hready = 1'b1;
    tick();
    check("rty_rereq_busreq", {31'd0, hbusreq}, 32'd1);
    check("rty_rereq_accept", {31'd0, ui_accept}, 32'd0);
    check("rty_rereq_done", {31'd0, ui_done}, 32'd0);
    hresp = 2'b00;
    tick();
    check("rty_addr2_htrans", {30'd0, htrans}, 32'd2);
    check("rty_addr2_haddr", haddr, 32'h8000_0040);
    check("rty_addr2_hsize", {29'd0, hsize}, 32'd1);
    tick();
    check("rty_data2_hwdata", hwdata, 32'h1234_1234);
    tick();
    check("rty_done", {31'd0, ui_done}, 32'd1);
    check("rty_done_error", {31'd0, ui_error}, 32'd0);
    tick();
    check("rty_idle_done", {31'd0, ui_done}, 32'd0);

    // Two-cycle ERROR response
    request(32'h0000_0100, 3'b010, 1'b0, 32'h0, 4'h0, 1'b0);
    tick();
    ui_valid = 1'b0;
    tick();
    check("err_addr_htrans", {30'd0, htrans}, 32'd2);
    tick();
    hready = 1'b0;
    hresp  = 2'b01;
    tick();
    check("err_resp2_done", {31'd0, ui_done}, 32'd0);
    hready = 1'b1;
    tick();
    check("err_done", {31'd0, ui_done}, 32'd1);
    check("err_error", {31'd0, ui_error}, 32'd1);
    hresp = 2'b00;
    tick();
    check("err_idle_htrans", {30'd0, htrans}, 32'd0);
    check("err_idle_busreq", {31'd0, hbusreq}, 32'd0);
    check("err_idle_error", {31'd0, ui_error}, 32'd0);

    // Grant withheld, then reset mid-REQ
    hgrant = 1'b0;
    request(32'h2000_0000, 3'b010, 1'b0, 32'h0, 4'h0, 1'b1);
    tick();
    check("gw_accept", {31'd0, ui_accept}, 32'd1);
    ui_valid = 1'b0;
    for (int i = 0; i < GRANT_WAIT; i++) begin
      tick();
      check("gw_busreq_wait", {31'd0, hbusreq}, 32'd1);
      check("gw_htrans_wait", {30'd0, htrans}, 32'd0);
    end
    resetn = 1'b0;
    #1;
    check("gw_rst_busreq", {31'd0, hbusreq}, 32'd0);
    check("gw_rst_hlock", {31'd0, hlock}, 32'd0);
    check("gw_rst_done", {31'd0, ui_done}, 32'd0);
    tick();
    check("gw_rst_done_hold", {31'd0, ui_done}, 32'd0);
    resetn = 1'b1;
    hgrant = 1'b1;
    tick();
    check("gw_post_rst_done", {31'd0, ui_done}, 32'd0);
    check("gw_post_rst_busreq", {31'd0, hbusreq}, 32'd0);

`ifdef AHBM_TIMEOUT_EN
    // Watchdog: hready held low in DATA for TIMEOUT_CYCLES cycles
    request(32'h3000_0000, 3'b010, 1'b0, 32'h0, 4'h0, 1'b0);
    tick();
    ui_valid = 1'b0;
    tick();
    tick();
    hready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("tmo_wait_done", {31'd0, ui_done}, 32'd0);
    end
    tick();
    check("tmo_done", {31'd0, ui_done}, 32'd1);
    check("tmo_error", {31'd0, ui_error}, 32'd1);
    check("tmo_htrans", {30'd0, htrans}, 32'd0);
    hready = 1'b1;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/picorv32_ahb_master.md
# picorv32_ahb_master

Single-transfer AHB 2.0 master for the GRLIB AMBA bus. It sits directly downstream of the PicoRV32 memory adapter and replaces the FreeAHB master. It takes one registered read or write request at a time, arbitrates for the bus, and runs one SINGLE/NONSEQ transfer. RETRY and SPLIT responses are re-issued automatically; ERROR and OKAY end the request with a one-cycle completion pulse.

## Interface
Parameters:
- HMASTER_ID, 0: value placed on hmaster_idx, the GRLIB index; informational only.
- TIMEOUT_CYCLES, 1023: watchdog limit, used only when AHBM_TIMEOUT_EN is defined. Legal range 1..65535.

Ports:
- clk  in  1  clock; all logic on rising edge
- resetn  in  1  reset, asynchronous, active-low
- ui_valid  in  1  request present; sampled only in IDLE
- ui_addr  in  32  byte address
- ui_size  in  3  000 byte, 001 half, 010 word; other codes treated as word
- ui_write  in  1  1 write, 0 read
- ui_wdata  in  32  write data, big-endian lane order, data in low-order bits of its size
- ui_prot  in  4  copied to hprot
- ui_lock  in  1  copied to hlock and held through the transfer
- ui_accept  out  1  one-cycle pulse: request captured
- ui_done  out  1  one-cycle pulse: transfer finished
- ui_error  out  1  valid with ui_done: ERROR response or timeout
- ui_rdata  out  32  raw hrdata captured at completion; valid with ui_done
- hbusreq, hlock  out  1
- hgrant, hready  in  1
- hresp  in  2  00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT
- htrans  out  2  00 IDLE, 10 NONSEQ only
- haddr  out  32
- hwrite  out  1
- hsize  out  3
- hburst  out  3  constant 000 (SINGLE)
- hprot  out  4
- hwdata  out  32
- hrdata  in  32
- hmaster_idx  out  4  constant HMASTER_ID

## Operation
- **Request capture.** In IDLE with ui_valid=1, the block registers addr, size, write, wdata, prot and lock, pulses ui_accept, and moves to REQ. The ui_* inputs are ignored until ui_done.
- **Write-data lane replication.** A byte is copied to all four lanes. A half-word is copied to both halves. A word passes through unchanged.
- **State machine.**
  - IDLE: waits for a request.
  - REQ: hbusreq=1. Moves to ADDR on a rising edge where hgrant=1 and hready=1.
  - ADDR: htrans=NONSEQ, with haddr, hwrite, hsize and hprot driven. Moves to DATA when hready=1.
  - DATA: htrans=IDLE, hwdata driven. The hready and hresp combination selects the next state:
    - hready=0, hresp=OKAY: wait state; stay in DATA.
    - hready=0, hresp=ERROR/RETRY/SPLIT: first cycle of the two-cycle response; go to RESP2.
    - hready=1, hresp=OKAY: capture hrdata, go to DONE.
  - RESP2: htrans=IDLE. On hready=1:
    - ERROR: go to DONE with ui_error=1.
    - RETRY or SPLIT: go to REQ; the captured request is re-issued unchanged.
  - DONE: ui_done=1 for exactly one cycle, then IDLE.
- **Bus request.** hbusreq is 1 in REQ and ADDR only. hlock follows the captured lock value from REQ to DONE inclusive.
- **Grant loss.** If hgrant falls in REQ, the block keeps waiting. Grant loss in ADDR or DATA is irrelevant because the address phase is already committed.
- **SPLIT.** No special treatment: the arbiter withholds hgrant until the slave releases the split.

## Timing
- **Reset values.** Every output is 0 and the state is IDLE. This includes htrans=IDLE, hburst=000 and hwdata=0. hmaster_idx is the constant HMASTER_ID.
- **Reset mid-transfer.** The block returns to IDLE immediately with all outputs 0. No ui_done is generated.
- **Minimum latency.** With hgrant held at 1 and a zero-wait slave:
  - cycle 0: ui_valid sampled.
  - cycle 1: ui_accept=1, REQ.
  - cycle 2: ADDR.
  - cycle 3: DATA.
  - cycle 4: DONE, ui_done=1.
  - Total: four cycles from capture to done.
- **Back-to-back requests.** A new ui_valid in the DONE cycle is not sampled. The earliest accept is the cycle after DONE.
- **Output registering.** All outputs are registered.

## Configuration
- **AHBM_TIMEOUT_EN** defined:
  - A 16-bit counter runs in DATA and RESP2. It clears on every state change and increments on each cycle with hready=0.
  - When the counter reaches TIMEOUT_CYCLES, the block goes to DONE with ui_error=1 and htrans=IDLE.
  - The counter also runs in REQ, so a grant that never arrives also times out.
- **AHBM_TIMEOUT_EN** not defined: no counter; the block waits indefinitely.

## Structure
- **Shared package `ahbm_pkg`.** Holds the state enum (IDLE, REQ, ADDR, DATA, RESP2, DONE) and the HTRANS, HRESP, HSIZE and HBURST constants. The adapter reuses this package.
- **Sub-module `ahbm_lane_rep`.** Combinational size-based wdata replication. This is the only sub-module.

## Test plan
- **Zero-wait word read.** Read 0x4000_0010, hgrant=1, hrdata=0xDEADBEEF -> ui_done at cycle 4, ui_rdata=0xDEADBEEF, ui_error=0, htrans=10 for exactly one cycle.
- **Byte write with wait states.** Byte write to 0x4000_0003, wdata=0x000000A5, two wait states -> hwdata=0xA5A5A5A5, hsize=000, ui_done three cycles after the first DATA cycle.
- **RETRY then OKAY.** RETRY on the first attempt, then OKAY -> two NONSEQ phases with identical haddr; exactly one ui_accept and one ui_done.
- **ERROR response.** Two-cycle ERROR -> ui_done with ui_error=1; bus idle afterwards.
- **Grant withheld, then reset.** hgrant=0 for 20 cycles, then resetn pulsed low mid-REQ -> hbusreq=1 during the wait, then all outputs 0 with no ui_done.
- **Timeout (AHBM_TIMEOUT_EN defined, TIMEOUT_CYCLES=8).** hready held at 0 in DATA -> ui_error=1 after 8 low cycles.
